coin_acceptor: RTL and testbench
================================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter: DEBOUNCE, default 4; consecutive synchronized cycles a single sensor must stay high to qualify a coin (legal 1..15).
REQ-002 Parameter: PULSE_LEN, default 1; cycles the coin code is driven per accepted coin (legal 1..7).
REQ-003 Parameter: COIN_GAP, default 2; idle cycles enforced after release before the next coin is qualified (legal 0..15).
REQ-004 clock  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clock.
REQ-006 nickel_in  input  1  raw nickel sensor level, asynchronous to clock.
REQ-007 dime_in  input  1  raw dime sensor level, asynchronous to clock.
REQ-008 enable  input  1  vend machine accepting coins; 0 forces rejection of new coins.
REQ-009 coin  output  2  coin code to vend FSM: 0 none, 1 nickel, 2 dime; 3 never driven.
REQ-010 reject  output  1  one-cycle pulse when a coin is rejected.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 accepted  output  8  count of accepted coins, wraps 255->0.

Function
REQ-013 Both raw sensors SHALL pass a 2-flop synchronizer; all FSM decisions use synchronized values only.
REQ-014 FSM states: IDLE, QUAL, EMIT, RELEASE, GAP, REJECT.
REQ-015 IDLE: exactly one synchronized sensor high -> QUAL (count=1, sensor type latched); both high -> REJECT; none -> stay.
REQ-016 QUAL: latched sensor high, other low -> count++; count reaching DEBOUNCE -> EMIT if enable=1, else REJECT.
REQ-017 QUAL: latched sensor drops before count reaches DEBOUNCE -> IDLE, no coin, no reject (glitch filter).
REQ-018 QUAL: other sensor rises -> REJECT.
REQ-019 EMIT: coin driven with latched code for exactly PULSE_LEN cycles, then -> RELEASE; accepted increments once, on EMIT entry.
REQ-020 Latency: stable raw input high at edge k -> coin nonzero from edge k+2+DEBOUNCE (6 cycles at defaults).
REQ-021 REJECT: reject=1 for exactly one cycle, then -> RELEASE; coin stays 0.
REQ-022 RELEASE: stay until both synchronized sensors low, then -> GAP (COIN_GAP>0) or IDLE (COIN_GAP=0).
REQ-023 GAP: count COIN_GAP cycles ignoring sensors, then -> IDLE.
REQ-024 coin SHALL be 0 in every state except EMIT; reject SHALL be 0 outside REJECT.
REQ-025 enable changes after QUAL->EMIT decision SHALL NOT abort an in-progress EMIT.
REQ-026 Sensor held high indefinitely SHALL produce exactly one coin or one reject.

Reset
REQ-027 reset=0 SHALL asynchronously force state IDLE, coin=0, reject=0, busy=0, accepted=0, counters and synchronizer flops to 0.
REQ-028 reset mid-EMIT SHALL clear coin immediately; accepted does not retain the in-flight increment.
REQ-029 After release, a sensor already high SHALL be treated as a new insertion (qualified normally).

Structure
REQ-030 Shared package vend_pkg SHALL hold coin code constants (COIN_NONE=0, COIN_NICKEL=1, COIN_DIME=2) and the acceptor state enum.
REQ-031 One sub-module coin_sync (2-flop synchronizer, parameter WIDTH) SHALL be instantiated for both sensors.
REQ-032 coin port ordering and encoding SHALL match the vend FSM coin input directly, no glue.

Verification
REQ-033 Defaults; nickel_in high 10 cycles -> coin=1 for 1 cycle at edge k+6, accepted=1, reject never.
REQ-034 dime_in high 3 cycles then low -> no coin, no reject, accepted unchanged, FSM back in IDLE.
REQ-035 nickel_in and dime_in high together 8 cycles -> reject one-cycle pulse, coin=0, accepted=0.
REQ-036 enable=0, dime_in high 8 cycles -> reject pulse at edge k+6, coin=0.
REQ-037 PULSE_LEN=3, three nickels then dime, sensors 8 high / 4 low -> coin sequence 1,1,1 (x3) then 2,2,2; accepted=4; a coin whose edge falls inside GAP is not qualified until GAP ends.
REQ-038 reset pulled low during EMIT of a dime -> coin=0 same cycle, accepted=0, IDLE after release.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared coin codes and acceptor state type for the vending machine coin path.
package vend_pkg;

    localparam logic [1:0] COIN_NONE   = 2'd0;
    localparam logic [1:0] COIN_NICKEL = 2'd1;
    localparam logic [1:0] COIN_DIME   = 2'd2;

    typedef enum logic [2:0] {
        ACC_IDLE,
        ACC_QUAL,
        ACC_EMIT,
        ACC_RELEASE,
        ACC_GAP,
        ACC_REJECT
    } acc_state_e;

endpackage

// File: rtl/coin_sync.sv
// Two-flop synchronizer bringing the raw coin sensor levels into the clock domain.
module coin_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces the nickel/dime sensors, emits a coin code or a reject
// pulse per insertion, then waits for release and a quiet gap before the next coin.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int DEBOUNCE  = 4,
    parameter int PULSE_LEN = 1,
    parameter int COIN_GAP  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       nickel_in,
    input  logic       dime_in,
    input  logic       enable,
    output logic [1:0] coin,
    output logic       reject,
    output logic       busy,
    output logic [7:0] accepted
);

    localparam logic [3:0] DEB_CNT   = 4'(DEBOUNCE);
    localparam logic [3:0] PULSE_CNT = 4'(PULSE_LEN);
    localparam logic [3:0] GAP_CNT   = 4'(COIN_GAP);

    logic [1:0] w_sync;
    logic       w_nick;
    logic       w_dime;
    logic       w_mine;
    logic       w_other;

    acc_state_e r_state;
    acc_state_e w_state_next;
    logic [3:0] r_count;
    logic [3:0] w_count_next;
    logic       r_is_dime;
    logic       w_is_dime_next;
    logic [7:0] r_accepted;
    logic       w_accept;

    coin_sync #(.WIDTH(2)) u_sync (
        .clock   (clock),
        .reset   (reset),
        .i_async ({dime_in, nickel_in}),
        .o_sync  (w_sync)
    );

    assign w_nick  = w_sync[0];
    assign w_dime  = w_sync[1];
    assign w_mine  = r_is_dime ? w_dime : w_nick;
    assign w_other = r_is_dime ? w_nick : w_dime;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ACC_IDLE;
            r_count    <= 4'd0;
            r_is_dime  <= 1'b0;
            r_accepted <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_is_dime  <= w_is_dime_next;
            if (w_accept) begin
                r_accepted <= r_accepted + 8'd1;
            end
        end
    end

    // r_count is shared: debounce length in QUAL, pulse length in EMIT, quiet time in GAP.
    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_is_dime_next = r_is_dime;
        w_accept       = 1'b0;
        case (r_state)
            ACC_IDLE: begin
                if (w_nick && w_dime) begin
                    w_state_next = ACC_REJECT;
                end else if (w_nick || w_dime) begin
                    w_state_next   = ACC_QUAL;
                    w_count_next   = 4'd1;
                    w_is_dime_next = w_dime;
                end
            end
            ACC_QUAL: begin
                if (w_other) begin
                    w_state_next = ACC_REJECT;
                end else if (r_count == DEB_CNT) begin
                    if (enable) begin
                        w_state_next = ACC_EMIT;
                        w_count_next = 4'd1;
                        w_accept     = 1'b1;
                    end else begin
                        w_state_next = ACC_REJECT;
                    end
                end else if (w_mine) begin
                    w_count_next = r_count + 4'd1;
                end else begin
                    w_state_next = ACC_IDLE;
                end
            end
            ACC_EMIT: begin
                if (r_count == PULSE_CNT) begin
                    w_state_next = ACC_RELEASE;
                end else begin
                    w_count_next = r_count + 4'd1;
                end
            end
            ACC_REJECT: begin
                w_state_next = ACC_RELEASE;
            end
            ACC_RELEASE: begin
                if (!w_nick && !w_dime) begin
                    if (COIN_GAP == 0) begin
                        w_state_next = ACC_IDLE;
                    end else begin
                        w_state_next = ACC_GAP;
                        w_count_next = 4'd1;
                    end
                end
            end
            ACC_GAP: begin
                if (r_count == GAP_CNT) begin
                    w_state_next = ACC_IDLE;
                end else begin
                    w_count_next = r_count + 4'd1;
                end
            end
            default: begin
                w_state_next = ACC_IDLE;
            end
        endcase
    end

    assign coin     = (r_state == ACC_EMIT) ? (r_is_dime ? COIN_DIME : COIN_NICKEL) : COIN_NONE;
    assign reject   = (r_state == ACC_REJECT);
    assign busy     = (r_state != ACC_IDLE);
    assign accepted = r_accepted;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed vector table, multi-cycle
// sequences, and random stimulus against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_coin_acceptor;

    localparam int DEBOUNCE  = 4;
    localparam int PULSE_LEN = 1;
    localparam int COIN_GAP  = 2;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       nickel_in = 1'b0;
    logic       dime_in   = 1'b0;
    logic       enable    = 1'b1;
    logic [1:0] coin;
    logic       reject;
    logic       busy;
    logic [7:0] accepted;
    logic [1:0] coin3;
    logic       reject3;
    logic       busy3;
    logic [7:0] accepted3;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int accExp   = 0;

    int coinEdge[$];
    int coinVal[$];
    int rejEdge[$];
    int coin3Val[$];
    int rej3Edge[$];

    typedef struct {
        logic nick;
        logic dime;
        logic en;
        int   hold;
        int   expCoin;
        int   expCoinLat;
        int   expCoinCycles;
        int   expRejects;
        int   expRejLat;
        int   expAccDelta;
    } vector_t;

    vector_t vecs[8];

    // reference model state: everything is expressed as edge timestamps
    int         mN;
    logic [1:0] mDl0;
    logic [1:0] mDl1;
    int         mFreeAt;
    int         mQualStart;
    logic       mQualing;
    logic       mQualDime;
    logic       mWaiting;
    int         mRelCheck;
    int         mEmitStart;
    int         mCode;
    int         mRejectEdge;
    int         mAcc;
    int         mExpCoin;
    int         mExpReject;
    int         mExpBusy;

    coin_acceptor #(.DEBOUNCE(DEBOUNCE), .PULSE_LEN(PULSE_LEN), .COIN_GAP(COIN_GAP)) dut (
        .clock     (clock),
        .reset     (reset),
        .nickel_in (nickel_in),
        .dime_in   (dime_in),
        .enable    (enable),
        .coin      (coin),
        .reject    (reject),
        .busy      (busy),
        .accepted  (accepted)
    );

    coin_acceptor #(.DEBOUNCE(4), .PULSE_LEN(3), .COIN_GAP(2)) dut3 (
        .clock     (clock),
        .reset     (reset),
        .nickel_in (nickel_in),
        .dime_in   (dime_in),
        .enable    (enable),
        .coin      (coin3),
        .reject    (reject3),
        .busy      (busy3),
        .accepted  (accepted3)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // event logger, sampled on the falling edge away from state updates
    always @(negedge clock) begin
        if (coin != 2'd0) begin
            coinEdge.push_back(cycle);
            coinVal.push_back(int'(coin));
        end
        if (reject) rejEdge.push_back(cycle);
        if (coin3 != 2'd0) coin3Val.push_back(int'(coin3));
        if (reject3) rej3Edge.push_back(cycle);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clearLogs();
        coinEdge.delete();
        coinVal.delete();
        rejEdge.delete();
        coin3Val.delete();
        rej3Edge.delete();
    endtask

    task automatic holdInputs(input logic n, input logic d, input int cyc);
        nickel_in = n;
        dime_in   = d;
        repeat (cyc) @(negedge clock);
    endtask

    task automatic modelInit();
        mN          = 0;
        mDl0        = 2'b00;
        mDl1        = 2'b00;
        mFreeAt     = 0;
        mQualStart  = 0;
        mQualing    = 1'b0;
        mQualDime   = 1'b0;
        mWaiting    = 1'b0;
        mRelCheck   = 0;
        mEmitStart  = -100;
        mCode       = 0;
        mRejectEdge = -100;
        mAcc        = 0;
    endtask

    task automatic modelReject();
        mRejectEdge = mN;
        mWaiting    = 1'b1;
        mRelCheck   = mN + 2;
        mQualing    = 1'b0;
    endtask

    // One rising edge: the acceptor sees raw sensor values from two edges earlier.
    task automatic modelStep();
        logic [1:0] s;
        logic       mine;
        logic       other;
        s    = mDl1;
        mDl1 = mDl0;
        mDl0 = {dime_in, nickel_in};
        if (mWaiting) begin
            if (mN >= mRelCheck && s == 2'b00) begin
                mWaiting = 1'b0;
                mFreeAt  = mN + COIN_GAP + 1;
            end
        end else if (mQualing) begin
            mine  = mQualDime ? s[1] : s[0];
            other = mQualDime ? s[0] : s[1];
            if (other) begin
                modelReject();
            end else if (mN - mQualStart == DEBOUNCE) begin
                if (enable) begin
                    mQualing   = 1'b0;
                    mEmitStart = mN;
                    mCode      = mQualDime ? 2 : 1;
                    mAcc       = (mAcc + 1) % 256;
                    mWaiting   = 1'b1;
                    mRelCheck  = mN + PULSE_LEN + 1;
                end else begin
                    modelReject();
                end
            end else if (!mine) begin
                mQualing = 1'b0;
                mFreeAt  = mN + 1;
            end
        end else if (mN >= mFreeAt) begin
            if (s == 2'b11) begin
                modelReject();
            end else if (s != 2'b00) begin
                mQualing   = 1'b1;
                mQualStart = mN;
                mQualDime  = s[1];
            end
        end
        mExpCoin   = (mN >= mEmitStart && mN < mEmitStart + PULSE_LEN) ? mCode : 0;
        mExpReject = (mN == mRejectEdge) ? 1 : 0;
        mExpBusy   = (mWaiting || mQualing || (mN + 1 < mFreeAt)) ? 1 : 0;
        mN++;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset     = 1'b0;
        nickel_in = 1'b0;
        dime_in   = 1'b0;
        enable    = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        modelInit();
    endtask

    task automatic applyStimulus(input vector_t v, input int idx);
        int k;
        int lat;
        clearLogs();
        enable = v.en;
        k = cycle + 1;
        holdInputs(v.nick, v.dime, v.hold);
        holdInputs(1'b0, 1'b0, 30);
        enable = 1'b1;
        accExp = accExp + v.expAccDelta;
        checkOutput($sformatf("vec%0d.coinCycles", idx), coinEdge.size(), v.expCoinCycles);
        if (v.expCoinCycles > 0) begin
            lat = (coinEdge.size() > 0) ? coinEdge[0] - k : -1;
            checkOutput($sformatf("vec%0d.coinLatency", idx), lat, v.expCoinLat);
            checkOutput($sformatf("vec%0d.coinValue", idx),
                        (coinVal.size() > 0) ? coinVal[0] : -1, v.expCoin);
        end
        checkOutput($sformatf("vec%0d.rejects", idx), rejEdge.size(), v.expRejects);
        if (v.expRejects > 0) begin
            lat = (rejEdge.size() > 0) ? rejEdge[0] - k : -1;
            checkOutput($sformatf("vec%0d.rejectLatency", idx), lat, v.expRejLat);
        end
        checkOutput($sformatf("vec%0d.accepted", idx), int'(accepted), accExp);
        checkOutput($sformatf("vec%0d.busyAfter", idx), int'(busy), 0);
    endtask

    initial begin
        int k;
        int k2;
        int waited;
        int pat;
        int len;
        int exp3[12];

        vecs[0] = '{1'b1, 1'b0, 1'b1, 10, 1, 6, 1, 0, 0, 1};
        vecs[1] = '{1'b0, 1'b1, 1'b1,  3, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{1'b1, 1'b1, 1'b1,  8, 0, 0, 0, 1, 2, 0};
        vecs[3] = '{1'b0, 1'b1, 1'b0,  8, 0, 0, 0, 1, 6, 0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 10, 2, 6, 1, 0, 0, 1};
        vecs[5] = '{1'b1, 1'b0, 1'b1,  4, 1, 6, 1, 0, 0, 1};
        vecs[6] = '{1'b1, 1'b0, 1'b1,  1, 0, 0, 0, 0, 0, 0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 25, 1, 6, 1, 0, 0, 1};

        $display("[TB] reset state");
        #2 reset = 1'b0;
        #1;
        checkOutput("reset.coin", int'(coin), 0);
        checkOutput("reset.reject", int'(reject), 0);
        checkOutput("reset.busy", int'(busy), 0);
        checkOutput("reset.accepted", int'(accepted), 0);
        checkOutput("reset.accepted3", int'(accepted3), 0);

        $display("[TB] vector table");
        doReset();
        accExp = 0;
        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

        $display("[TB] PULSE_LEN=3 coin train");
        doReset();
        clearLogs();
        for (int c = 0; c < 4; c++) begin
            holdInputs(c < 3, c == 3, 8);
            holdInputs(1'b0, 1'b0, 4);
        end
        holdInputs(1'b0, 1'b0, 20);
        for (int i = 0; i < 12; i++) exp3[i] = (i < 9) ? 1 : 2;
        checkOutput("train.coinCycles3", coin3Val.size(), 12);
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("train.coin3[%0d]", i),
                        (i < coin3Val.size()) ? coin3Val[i] : -1, exp3[i]);
        end
        checkOutput("train.accepted3", int'(accepted3), 4);
        checkOutput("train.rejects3", rej3Edge.size(), 0);
        checkOutput("train.coinCycles1", coinEdge.size(), 4);
        checkOutput("train.accepted1", int'(accepted), 4);

        $display("[TB] coin arriving during gap");
        doReset();
        clearLogs();
        k = cycle + 1;
        holdInputs(1'b1, 1'b0, 8);
        holdInputs(1'b0, 1'b0, 2);
        k2 = cycle + 1;
        holdInputs(1'b1, 1'b0, 8);
        holdInputs(1'b0, 1'b0, 20);
        checkOutput("gap.coinCount", coinEdge.size(), 2);
        checkOutput("gap.firstLatency", (coinEdge.size() > 0) ? coinEdge[0] - k : -1, 6);
        checkOutput("gap.secondLatency", (coinEdge.size() > 1) ? coinEdge[1] - k2 : -1, 7);

        $display("[TB] reset during dime emit");
        doReset();
        clearLogs();
        dime_in = 1'b1;
        waited = 0;
        while (coin != 2'd2 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("midEmit.reached", (coin == 2'd2) ? 1 : 0, 1);
        #2;
        reset   = 1'b0;
        dime_in = 1'b0;
        #1;
        checkOutput("midEmit.coin", int'(coin), 0);
        checkOutput("midEmit.accepted", int'(accepted), 0);
        checkOutput("midEmit.busy", int'(busy), 0);
        clearLogs();
        @(negedge clock);
        reset = 1'b1;
        holdInputs(1'b0, 1'b0, 15);
        checkOutput("midEmit.busyAfter", int'(busy), 0);
        checkOutput("midEmit.acceptedAfter", int'(accepted), 0);
        checkOutput("midEmit.noCoinAfter", coinEdge.size(), 0);

        $display("[TB] random stimulus against reference model");
        doReset();
        for (int seg = 0; seg < 70; seg++) begin
            pat = $urandom_range(0, 5);
            len = (seg == 69) ? 30 : $urandom_range(1, 12);
            if (seg == 69) pat = 0;
            enable    = ($urandom_range(0, 7) != 0);
            nickel_in = (pat == 1 || pat == 2 || pat == 5);
            dime_in   = (pat == 3 || pat == 4 || pat == 5);
            for (int c = 0; c < len; c++) begin
                @(posedge clock);
                modelStep();
                @(negedge clock);
                checkOutput($sformatf("rand.coin@%0d", cycle), int'(coin), mExpCoin);
                checkOutput($sformatf("rand.reject@%0d", cycle), int'(reject), mExpReject);
                checkOutput($sformatf("rand.busy@%0d", cycle), int'(busy), mExpBusy);
                checkOutput($sformatf("rand.accepted@%0d", cycle), int'(accepted), mAcc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
